// File: rtl/led_pattern_gen.sv
// led_pattern_gen: run-time selectable LED pattern engine with programmable step rate and pause.
// Define LED_BREATHE_EN to build the PWM breathe pattern for mode 6; otherwise mode 6 drives the LEDs off.
module led_pattern_gen #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          mode,
    input  logic [31:0]         step_div,
    input  logic                pause,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);
    localparam int PW = $clog2(NUM_LEDS + 1);
    localparam logic [PW-1:0] TOP  = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0] LTOP = PW'(NUM_LEDS);
    localparam logic [2:0] M_OFF     = 3'd0;
    localparam logic [2:0] M_BLINK   = 3'd1;
    localparam logic [2:0] M_COUNT   = 3'd2;
    localparam logic [2:0] M_KNIGHT  = 3'd3;
    localparam logic [2:0] M_ROTATE  = 3'd4;
    localparam logic [2:0] M_BAR     = 3'd5;
    localparam logic [2:0] M_BREATHE = 3'd6;
    localparam logic [2:0] M_ALL_ON  = 3'd7;

    logic [2:0]          mode_q, mode_n;
    logic [31:0]         tick_cnt, cnt_n;
    logic [PW-1:0]       pos, pos_n, level, level_n;
    logic                dir, dir_n, phase, phase_n, mode_chg, step;
    logic [NUM_LEDS-1:0] count, count_n, led_n, br_led;

    always_comb begin
        mode_chg = mode != mode_q;
        step     = !mode_chg && !pause && tick_cnt >= step_div;
        mode_n   = mode_chg ? mode : mode_q;
        cnt_n    = (mode_chg || step) ? '0 : pause ? tick_cnt : tick_cnt + 32'd1;
        // dir=1 means travelling down; each end is shown for a single step
        pos_n    = mode_chg ? '0
                 : !step ? pos
                 : mode_q == M_KNIGHT ? (dir ? (pos == '0 ? PW'(1) : pos - PW'(1))
                                             : (pos == TOP ? TOP - PW'(1) : pos + PW'(1)))
                 : mode_q == M_ROTATE ? (pos == TOP ? '0 : pos + PW'(1))
                 : pos;
        dir_n    = mode_chg ? 1'b0 : (step && mode_q == M_KNIGHT) ? (dir ? pos != '0 : pos == TOP) : dir;
        level_n  = mode_chg ? '0 : (step && mode_q == M_BAR) ? (level == LTOP ? '0 : level + PW'(1)) : level;
        count_n  = mode_chg ? '0 : (step && mode_q == M_COUNT) ? count + NUM_LEDS'(1) : count;
        phase_n  = mode_chg ? 1'b0 : (step && mode_q == M_BLINK) ? !phase : phase;
        led_n    = mode_n == M_BLINK   ? {NUM_LEDS{phase_n}}
                 : mode_n == M_COUNT   ? count_n
                 : (mode_n == M_KNIGHT || mode_n == M_ROTATE) ? NUM_LEDS'(1) << pos_n
                 : mode_n == M_BAR     ? ~({NUM_LEDS{1'b1}} << level_n)
                 : mode_n == M_BREATHE ? br_led
                 : mode_n == M_ALL_ON  ? {NUM_LEDS{1'b1}}
                 : {NUM_LEDS{1'b0}};
    end

`ifdef LED_BREATHE_EN
    logic [7:0] duty, duty_n, pwm_cnt, pwm_n;
    logic       bdir, bdir_n;

    always_comb begin
        pwm_n  = pwm_cnt + 8'd1;
        duty_n = mode_chg ? 8'd0
               : !(step && mode_q == M_BREATHE) ? duty
               : bdir ? (duty == 8'd0 ? 8'd1 : duty - 8'd1)
               : (duty == 8'hff ? 8'hfe : duty + 8'd1);
        bdir_n = mode_chg ? 1'b0 : (step && mode_q == M_BREATHE) ? (bdir ? duty != 8'd0 : duty == 8'hff) : bdir;
        br_led = {NUM_LEDS{pwm_n < duty_n}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty    <= '0;
            bdir    <= 1'b0;
            pwm_cnt <= '0;
        end else begin
            duty    <= duty_n;
            bdir    <= bdir_n;
            pwm_cnt <= pwm_n;
        end
    end
`else
    assign br_led = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= M_OFF;
            tick_cnt <= '0;
            pos      <= '0;
            dir      <= 1'b0;
            level    <= '0;
            count    <= '0;
            phase    <= 1'b0;
            led      <= '0;
            tick     <= 1'b0;
        end else begin
            mode_q   <= mode_n;
            tick_cnt <= cnt_n;
            pos      <= pos_n;
            dir      <= dir_n;
            level    <= level_n;
            count    <= count_n;
            phase    <= phase_n;
            led      <= led_n;
            tick     <= step;
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench; expected LED value per tick is queued, a monitor checks each tick.
module tb_led_pattern_gen;
    typedef struct {
        logic [7:0] led;
        int         gap;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mode;
    logic [31:0] step_div;
    logic        pause;
    logic [7:0]  led;
    logic        tick;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_tick = 0;
    item_t       sbq[$];
    logic [7:0]  kn [15];

    led_pattern_gen #(.CLK_FREQ(100_000_000), .NUM_LEDS(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .step_div(step_div),
        .pause(pause), .led(led), .tick(tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        item_t it;
        if (rst_n === 1'b1 && tick === 1'b1) begin
            if (sbq.size() != 0) begin
                it = sbq.pop_front();
                chk("step_led", led, it.led);
                if (it.gap != 0) chk("step_gap", cyc - last_tick, it.gap);
            end
            last_tick = cyc;
        end
    end

    task automatic go(input logic [2:0] m, input logic [31:0] sd, input logic p);
        @(negedge clk);
        #1;
        mode = m;
        step_div = sd;
        pause = p;
    endtask

    task automatic nwait(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v, input int g);
        sbq.push_back('{v, g});
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected steps never arrived", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic wait_tick(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < budget);
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: tick %0b expected 1 within %0d cycles", tick, budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, ons, offs, ticks;
        kn = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        rst_n = 1'b0;
        mode = 3'd0;
        step_div = 32'd3;
        pause = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_led", led, 8'h00);
        chk("reset_tick", tick, 1'b0);
        #1 rst_n = 1'b1;
        nwait(10);
        chk("off_led", led, 8'h00);

        go(3'd3, 32'd3, 1'b0);
        for (int i = 0; i < 15; i++) push(kn[i], i == 0 ? 0 : 4);
        @(negedge clk);
        chk("knight_init_led", led, 8'h01);
        chk("knight_init_tick", tick, 1'b0);
        drain("knight", 100);

        go(3'd2, 32'd3, 1'b0);
        for (int i = 0; i < 256; i++) push(8'((i + 1) % 256), i == 0 ? 0 : 4);
        @(negedge clk);
        chk("count_init_led", led, 8'h00);
        drain("count", 1100);

        go(3'd5, 32'd3, 1'b0);
        for (int i = 0; i < 18; i++) push(8'((9'd1 << ((i + 1) % 9)) - 9'd1), i == 0 ? 0 : 4);
        drain("bar", 120);

        go(3'd4, 32'd3, 1'b0);
        push(8'h02, 0);
        push(8'h04, 4);
        push(8'h08, 4);
        drain("rotate", 40);
        wait_tick(10);
        nwait(3);
        mode = 3'd1;
        push(8'hff, 0);
        @(negedge clk);
        chk("chg_on_tick_led", led, 8'h00);
        chk("chg_on_tick_tick", tick, 1'b0);
        repeat (3) @(negedge clk);
        chk("blink_pre_led", led, 8'h00);
        @(negedge clk);
        chk("blink_on_led", led, 8'hff);
        chk("blink_on_tick", tick, 1'b1);
        #1 pause = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (led !== 8'hff || tick !== 1'b0) bad++;
        end
        chk("pause_hold_bad_cycles", bad, 0);
        #1 pause = 1'b0;
        push(8'h00, 0);
        drain("blink_resume", 20);

        go(3'd2, 32'd100, 1'b0);
        nwait(51);
        chk("div_pre_tick", tick, 1'b0);
        chk("div_pre_led", led, 8'h00);
        step_div = 32'd2;
        push(8'h01, 0);
        push(8'h02, 3);
        push(8'h03, 3);
        push(8'h04, 3);
        @(negedge clk);
        chk("div_lower_tick", tick, 1'b1);
        drain("div_lower", 30);

        #3;
        chk("pre_reset_led", led, 8'h04);
        rst_n = 1'b0;
        #1;
        chk("async_reset_led", led, 8'h00);
        chk("async_reset_tick", tick, 1'b0);
        nwait(3);
        rst_n = 1'b1;
        push(8'h01, 0);
        push(8'h02, 3);
        drain("post_reset", 30);

        go(3'd7, 32'd3, 1'b0);
        @(negedge clk);
        chk("all_on_led", led, 8'hff);
        go(3'd0, 32'd3, 1'b0);
        @(negedge clk);
        chk("off_again_led", led, 8'h00);

`ifdef LED_BREATHE_EN
        go(3'd6, 32'd0, 1'b0);
        nwait(65);
        pause = 1'b1;
        ons = 0;
        offs = 0;
        repeat (256) begin
            @(negedge clk);
            if (led === 8'hff) ons++;
            else if (led === 8'h00) offs++;
        end
        chk("breathe_on_cycles", ons, 64);
        chk("breathe_off_cycles", offs, 192);
`else
        go(3'd6, 32'd3, 1'b0);
        bad = 0;
        ticks = 0;
        repeat (40) begin
            @(negedge clk);
            if (led !== 8'h00) bad++;
            if (tick === 1'b1) ticks++;
        end
        chk("mode6_off_bad_cycles", bad, 0);
        chk("mode6_tick_count", ticks, 9);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine for the KV260 PL. It drives NUM_LEDS outputs with one of eight patterns, selected at run time by a 3-bit mode word that PS software writes through AXI GPIO. A software-programmable step divider sets the pattern rate, and a pause input freezes the pattern. The block sits between the PS-controlled GPIO registers and the LED pins, clocked by pl_clk0.

## Interface
- CLK_FREQ, 100_000_000: clock frequency in Hz. Documentation and bench scaling only; not used in logic.
- NUM_LEDS, 8: number of LED outputs. Legal range is 2..32.
- clk  in  1  pl_clk0 from PS. Single clock domain.
- rst_n  in  1  pl_resetn0. Asynchronous, active-low.
- mode  in  3  pattern select from AXI GPIO. Quasi-static, already synchronous to clk.
- step_div  in  32  cycles per step minus 1. A value of 0 advances the pattern every cycle.
- pause  in  1  while 1, the tick counter and pattern state hold.
- led  out  NUM_LEDS  registered LED drive. Bit 0 is the rightmost LED.
- tick  out  1  one-cycle pulse, asserted on each pattern step.

## Operation
- Mode encoding:
  - 0 OFF
  - 1 BLINK
  - 2 COUNT
  - 3 KNIGHT
  - 4 ROTATE
  - 5 BAR
  - 6 BREATHE
  - 7 ALL_ON
- Tick generator: 32-bit tick_cnt.
  - When tick_cnt >= step_div, the block asserts tick for that cycle and loads tick_cnt with 0. Otherwise tick_cnt increments.
  - Because the compare is >=, lowering step_div below the current tick_cnt produces an immediate tick. The counter never runs away.
- Mode change: mode_q holds the registered copy of mode. When mode != mode_q at a clock edge, that edge does all of the following:
  - loads mode_q;
  - clears tick_cnt, pos, dir, count, level, duty and the breathe direction;
  - suppresses tick.
  - This takes priority over tick and over pause.
- Per-mode state, advanced only on tick:
  - BLINK: phase toggles. led is all-ones when phase=1, else 0. Initial phase is 0.
  - COUNT: NUM_LEDS-bit count increments and wraps from 2^NUM_LEDS-1 to 0. led = count.
  - KNIGHT: led = 1<<pos.
    - Going up: pos increments. At pos=NUM_LEDS-1 the next step sets dir to down and pos to NUM_LEDS-2.
    - Going down: at pos=0 the next step sets dir to up and pos to 1.
    - Each end is lit for exactly one step.
  - ROTATE: led = 1<<pos. pos increments and wraps from NUM_LEDS-1 to 0.
  - BAR: led = (1<<level)-1. level steps through 0..NUM_LEDS, then wraps to 0, for a period of NUM_LEDS+1 steps. level=NUM_LEDS means all LEDs on.
  - BREATHE:
    - duty is an 8-bit triangle. It rises by 1 per tick from 0 to 255, then falls by 1 per tick to 0. Each endpoint holds for one step.
    - pwm_cnt is an 8-bit free-running counter. It increments every cycle, ignores pause and is never cleared except by reset.
    - Every LED bit = (pwm_cnt < duty). At duty=0 the LEDs are always off; at duty=255 they are off 1 cycle in 256.
  - OFF: led = 0. ALL_ON: led = all-ones. Both ignore tick.
- pause=1 holds tick_cnt and all pattern state, and forces tick=0. led keeps its current pattern; BREATHE PWM keeps running at the frozen duty.

## Timing
- Reset values:
  - led = 0, tick = 0
  - mode_q = 0, tick_cnt = 0, pwm_cnt = 0
  - all pattern state = 0; dir = up
- led is registered from the next-state pattern state, so it reflects a step on the same edge that advances the state.
  - tick and the new led value appear on the same cycle boundary.
- Mode change sampled at edge k: led shows the new mode's initial pattern after edge k.
  - The first tick comes step_div+1 cycles later.
- Step period is step_div+1 cycles, for example 0x5F5E0FF gives 1 Hz at 100 MHz.
- step_div is sampled every cycle. Changes take effect without restarting the pattern.
- When reset asserts mid-pattern, led and all state go to reset values asynchronously. After release, the first edge with mode != 0 is treated as a mode change.
- When a tick and a mode change coincide, the mode change wins and no step occurs.

## Configuration
- LED_BREATHE_EN:
  - Defined: mode 6 is BREATHE, with pwm_cnt, duty and direction logic present.
  - Undefined: the BREATHE logic is removed and mode 6 behaves exactly as OFF (led = 0, tick still pulses).

## Test plan
All scenarios use NUM_LEDS=8 and step_div=3 (one tick every 4 cycles) unless stated otherwise.
- Reset then mode=3 → led sequence 01,02,04,…,80,40,20,…,01,02, with one step per 4 cycles and 0x80 and 0x01 each held for exactly one step.
- mode=2 for 256 ticks → led counts 00..FF and then wraps to 00; tick pulses are exactly 4 cycles apart.
- mode=5 → led sequence 00,01,03,07,…,FF,00, repeating with period 9 steps.
- mode=4 mid-run, switched to mode=1 on a tick cycle → no step on that edge, led=00 after the edge, then FF after 4 more cycles. With pause=1 held for 20 cycles, led stays constant and tick=0.
- step_div changed from 100 to 2 while tick_cnt=50 → tick on the next cycle, then every 3 cycles. Asserting rst_n=0 asynchronously mid-cycle → led=00 immediately.
- With LED_BREATHE_EN defined, mode=6 and step_div=0 → over 256 cycles at duty=64, led=FF for 64 cycles and 00 for 192. Without the macro, mode=6 gives led=00 constant.
